pwm_multi: RTL
==============

# pwm_multi

Multi-channel, parametrised PWM generator: the successor to the single-channel fixed-degree PWM. One shared period counter drives CHANNELS comparators. The block adds a runtime-programmable period, edge- or center-aligned counting, and double-buffered (shadow) configuration that updates only at period boundaries, so outputs never glitch. It sits between register/control logic and the LED and motor pins.

## Interface
- CHANNELS, 4: number of PWM outputs, 1..16.
- WIDTH, 10: width of the counter, period and duty values.
- RESET_PERIOD, 99: active period value after reset, < 2^WIDTH.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- enable  in  1  run/stop for the counter and outputs.
- cfg_period  in  WIDTH  new top value P.
- cfg_duty  in  CHANNELS*WIDTH  new duties; channel i uses bits [i*WIDTH +: WIDTH].
- cfg_center  in  1  new mode: 0 = edge-aligned, 1 = center-aligned.
- cfg_load  in  1  one-cycle strobe that captures cfg_period, cfg_duty and cfg_center.
- cfg_pending  out  1  high while captured values wait for a period boundary.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_tail  out  1  high during the last cycle of each period.

## Operation
- Register sets:
  - Active set (period, duties, mode) drives the counter and comparators.
  - Pending set is written by cfg_load.
- Edge mode counter sequence: 0,1,…,P,0. Period is P+1 cycles.
- Center mode counter sequence: 0↑P, then P−1↓1, then 0. Period is 2P cycles.
  - An up/down direction flag is held internally.
  - Center mode with P = 0 behaves as edge mode with P = 0.
- Comparator: channel i high when counter < duty_i.
  - duty = 0 gives constant low.
  - duty ≥ P+1 gives constant high (saturates; no wrap).
  - Center mode produces a pulse symmetric about the counter value 0.
- period_tail asserts when the counter is on its last value:
  - edge mode: counter == P;
  - center mode: counting down and counter == 1;
  - P = 0: asserts every cycle.
- Shadow transfer happens in a cycle where period_tail = 1 and enable = 1:
  - if cfg_load = 1 the same cycle, active ← cfg_* inputs directly and pending is cleared;
  - else, if cfg_pending = 1, active ← pending set and cfg_pending clears;
  - the counter restarts at 0, direction up, using the new set in the next cycle.
- cfg_load outside a tail cycle while enabled: pending ← inputs, cfg_pending ← 1. A second load before the boundary overwrites the pending set (last write wins).
- enable = 0:
  - counter held at 0, direction up;
  - pwm_out forced low; period_tail low;
  - cfg_load writes the active set directly, and cfg_pending clears.
- enable rising: the first period starts at counter 0 in the next cycle.
- Reset state:
  - counter 0, direction up;
  - active period = RESET_PERIOD, all duties 0, edge mode;
  - pending set 0, cfg_pending 0, pwm_out 0, period_tail 0.
  - rst mid-period overrides everything, including a simultaneous cfg_load.

## Timing
- pwm_out has one cycle of latency from the counter value (registered compare).
- period_tail is combinational from the counter, direction and active period, in the same cycle as the last counter value.
- A configuration change reaches the first pwm_out edge at most one full period plus 2 cycles after cfg_load.
- cfg_pending rises in the cycle after cfg_load and falls in the cycle after the transfer.
- No combinational path from cfg_* inputs to pwm_out.

## Configuration
- Macro PWM_MULTI_POLARITY_EN.
- Defined:
  - adds input cfg_invert [CHANNELS-1:0], captured by cfg_load and shadowed like the duties;
  - channel i output = compare XOR invert_i;
  - with enable = 0 or in reset, the output equals invert_i (idle level follows polarity).
- Undefined: no cfg_invert port; all outputs are active-high with idle low.

## Test plan
- Reset, enable = 1, defaults: period_tail pulses every 100 cycles; pwm_out = 0 on all channels.
- Edge mode, load P = 9 and duties {0,3,10,15} while disabled, then enable:
  - ch0 always low; ch1 high 3 of 10 cycles; ch2 and ch3 always high;
  - period_tail every 10 cycles.
- Center mode, P = 4, duty 2:
  - counter sequence 0,1,2,3,4,3,2,1;
  - pwm_out high for 3 cycles per 8-cycle period, centered on counter 0;
  - period_tail on the counter value 1 while counting down.
- Shadow timing, edge mode P = 9:
  - cfg_load duty 5 at counter = 3: cfg_pending = 1, and the old duty persists until the tail;
  - the new width appears from the next period.
  - A second load before the tail overwrites the pending set.
  - A load exactly on the tail cycle applies immediately.
- P = 0: period_tail is constant high; duty 1 gives constant high; duty 0 gives constant low.
- rst asserted mid-period with cfg_pending = 1: next cycle all outputs 0, cfg_pending 0, period back to RESET_PERIOD.

Source files
------------

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with a shared counter and period-boundary shadow config
// Optional output polarity control is built when PWM_MULTI_POLARITY_EN is defined.
module pwm_multi #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 10,
    parameter int RESET_PERIOD = 99
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic [CHANNELS*WIDTH-1:0] cfg_duty,
    input  logic                      cfg_center,
    input  logic                      cfg_load,
`ifdef PWM_MULTI_POLARITY_EN
    input  logic [CHANNELS-1:0]       cfg_invert,
`endif
    output logic                      cfg_pending,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tail
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]          cnt;
    logic                      down;

    logic [WIDTH-1:0]          act_period;
    logic [CHANNELS*WIDTH-1:0] act_duty;
    logic                      act_center;
    logic [CHANNELS-1:0]       act_inv;

    logic [WIDTH-1:0]          pend_period;
    logic [CHANNELS*WIDTH-1:0] pend_duty;
    logic                      pend_center;
    logic [CHANNELS-1:0]       pend_inv;

    logic [CHANNELS-1:0]       inv_in;
    logic [CHANNELS-1:0]       cmp;

`ifdef PWM_MULTI_POLARITY_EN
    assign inv_in = cfg_invert;
`else
    assign inv_in = '0;
`endif

    // P = 1 in center mode never reaches the down leg, so its tail is the single visit to 1.
    always_comb begin
        period_tail = 1'b0;
        if (enable) begin
            if (act_period == '0)
                period_tail = 1'b1;
            else if (!act_center)
                period_tail = (cnt == act_period);
            else
                period_tail = (cnt == ONE) && (down || act_period == ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (!enable || period_tail) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (!act_center) begin
            cnt <= cnt + ONE;
        end else if (down) begin
            cnt <= cnt - ONE;
        end else if (cnt == act_period) begin
            down <= 1'b1;
            cnt  <= cnt - ONE;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // A load in a disabled or tail cycle bypasses the shadow set; otherwise it waits in pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_period  <= WIDTH'(RESET_PERIOD);
            act_duty    <= '0;
            act_center  <= 1'b0;
            act_inv     <= '0;
            pend_period <= '0;
            pend_duty   <= '0;
            pend_center <= 1'b0;
            pend_inv    <= '0;
            cfg_pending <= 1'b0;
        end else if (cfg_load && (!enable || period_tail)) begin
            act_period  <= cfg_period;
            act_duty    <= cfg_duty;
            act_center  <= cfg_center;
            act_inv     <= inv_in;
            cfg_pending <= 1'b0;
        end else if (period_tail && cfg_pending) begin
            act_period  <= pend_period;
            act_duty    <= pend_duty;
            act_center  <= pend_center;
            act_inv     <= pend_inv;
            cfg_pending <= 1'b0;
        end else if (cfg_load) begin
            pend_period <= cfg_period;
            pend_duty   <= cfg_duty;
            pend_center <= cfg_center;
            pend_inv    <= inv_in;
            cfg_pending <= 1'b1;
        end
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++)
            cmp[i] = (cnt < act_duty[i*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            pwm_out <= '0;
        else if (enable)
            pwm_out <= cmp ^ act_inv;
        else
            pwm_out <= act_inv;
    end

endmodule
